pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
// - Parametrised hazard/forwarding controller for the 5-stage core; sits beside the ID-stage decoder.
// - Generates N-source forwarding selects, load-use bubbles and branch flushes, and holds the halt latch.
// - Tracks one in-flight multi-cycle mul/div op with a register scoreboard and stalls ID on RAW or structural hazards.
// PARAMETERS
// - NUM_FWD  2  forwarding source stages after ID (1=EX, 2=DM, ...); 1..4
// - MUL_LAT  4  mul/div-unit cycles for a multiply (>=2)
// - DIV_LAT  16 mul/div-unit cycles for a divide (>=2)
// - RA_W     5  register-address width
// PORTS
// - clk          in  1              rising-edge clock
// - rst          in  1              asynchronous, active-high reset
// - id_req_a/b   in  RA_W           ID-stage source register addresses
// - id_use_a/b   in  1              ID instruction really reads that operand
// - stg_w_en     in  NUM_FWD        stage k holds an instruction writing the regfile (bit k-1)
// - stg_req_w    in  NUM_FWD*RA_W   destination register of stage k (slice k-1)
// - stg_is_load  in  NUM_FWD        stage k instruction is a load
// - md_start     in  1              ID instruction issues a mul/div
// - md_is_div    in  1              1 = divide latency, 0 = multiply latency
// - md_req_w     in  RA_W           mul/div destination register
// - branch_taken in  1              EX resolved a taken branch/jump
// - syscall_halt in  1              EX holds a halting syscall
// - fwd_sel_a/b  out $clog2(NUM_FWD+1)  0 = regfile, k = forward from stage k
// - stall_if/id  out 1              hold PC / IF-ID register
// - flush_id     out 1              clear IF-ID register (wrong-path instruction)
// - flush_ex     out 1              insert a bubble into ID-EX
// - md_busy      out 1              mul/div op in flight
// - md_done      out 1              one-cycle pulse: result ready, write back md_wb_req
// - md_wb_req    out RA_W           mul/div destination, valid with md_done
// - halted       out 1              core halted; sticky until rst
// BEHAVIOUR
// - Reset (async): md FSM IDLE, counter 0, scoreboard 0, md_busy/md_done/halted 0, md_wb_req 0.
//   While rst is high, stall_if=stall_id=1 and all other comb outputs are 0.
// - Forwarding (comb, 0 latency): fwd_sel_x is the smallest k with stg_w_en[k-1], stg_req_w[k-1]==id_req_x
//   and id_use_x; otherwise 0. Register 0 is never forwarded (sel 0).
// - Load-use: stage 1 is a load and it matches a used operand -> stall_if=stall_id=flush_ex=1 for that cycle.
//   The forwarding select for that operand is don't-care; the stage-1 load is never forwarded.
// - Scoreboard RAW: a used operand whose bit is set (reg!=0) -> stall_if=stall_id=flush_ex=1.
// - Structural: md_start while md_busy -> stall_if=stall_id=flush_ex=1; the new op is not accepted.
// - md FSM IDLE->BUSY->DONE->IDLE:
//   IDLE: md_start && !stall_id && !branch_taken -> counter = (md_is_div ? DIV_LAT : MUL_LAT) - 1,
//         latch md_wb_req, set scoreboard[md_req_w] (none for reg 0), enter BUSY.
//   BUSY: md_busy=1; decrement each cycle; at counter 0 -> DONE.
//   DONE: md_done=1 for exactly one cycle; scoreboard bit cleared on exit; md_busy=0.
//         A new md_start is accepted in DONE; it goes straight to BUSY.
//   Issue to md_done spacing: exactly LAT cycles.
// - Branch: branch_taken -> flush_id=1 and flush_ex=1; overrides any load-use/RAW stall
//   (stall_if=stall_id=0), because the stalled instruction is wrong-path. Any md_start that cycle is ignored.
// - Halt: syscall_halt sets halted on the next edge. While halted: stall_if=stall_id=flush_ex=1.
//   An in-flight md op still completes and pulses md_done.
// - Simultaneous stall sources OR together. The counter never wraps; rst mid-op drops the op
//   with no md_done pulse.
// STRUCTURE
// - Shared header Core.vh gains MD_ST_IDLE/BUSY/DONE encodings, the FWD_SEL_RF=0 constant and the FWD_SEL_BIT macro.
// - One sub-module md_scoreboard: 2^RA_W-bit set/clear vector with a 2-port lookup; the rest stays inline.
// TESTING
// - EX writes r8, ID reads r8 in a (NUM_FWD=2) -> fwd_sel_a=1; EX and DM both write r8 -> fwd_sel_a=1 (youngest).
// - DM writes r0, ID reads r0 -> fwd_sel_a=0, no stall.
// - Stage-1 lw r9, ID uses r9 in b -> one cycle stall_if=stall_id=flush_ex=1; next cycle (load in DM) fwd_sel_b=2.
// - div to r10 issued (DIV_LAT=16); ID reads r10 -> stalled 16 cycles; md_done pulses once with md_wb_req=10;
//   the following cycle the read proceeds.
// - mul in flight plus a second md_start -> structural stall until DONE, then the second op is accepted;
//   branch_taken during a RAW stall -> flush_id=flush_ex=1, stall_if=0.
// - syscall_halt -> halted=1 next cycle and stays 1; assert rst mid-divide -> md_busy=0 and halted=0 immediately,
//   no md_done.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   md_state_e  : mul/div tracker states
//   FWD_SEL_RF  : forwarding select value meaning "read the regfile"
package pipe_hazard_unit_pkg;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_BUSY = 2'd1,
    MD_ST_DONE = 2'd2
  } md_state_e;

  localparam int FWD_SEL_RF = 0;

endpackage

// File: rtl/pipe_hazard_unit_md_scoreboard.sv
// md_scoreboard: one pending-write bit per architectural register, with a
// two-port combinational lookup for the ID-stage source operands.
//   clk, rst            : clock, async active-high reset (clears all bits)
//   i_set / i_set_req   : mark a register as pending (register 0 is never marked)
//   i_clr / i_clr_req   : release a pending register
//   i_rd_a / i_rd_b     : lookup addresses
//   o_hit_a / o_hit_b   : lookup register is pending
module md_scoreboard #(
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set,
  input  logic [RA_W-1:0] i_set_req,
  input  logic            i_clr,
  input  logic [RA_W-1:0] i_clr_req,
  input  logic [RA_W-1:0] i_rd_a,
  input  logic [RA_W-1:0] i_rd_b,
  output logic            o_hit_a,
  output logic            o_hit_b
);

  logic [(1<<RA_W)-1:0] r_sb;
  logic [(1<<RA_W)-1:0] w_sb_nxt;

  // Set is applied after clear so a new op reusing the retiring op's
  // destination keeps its bit.
  always_comb begin
    w_sb_nxt = r_sb;
    if (i_clr)                    w_sb_nxt[i_clr_req] = 1'b0;
    if (i_set && i_set_req != '0) w_sb_nxt[i_set_req] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sb <= '0;
    else     r_sb <= w_sb_nxt;
  end

  assign o_hit_a = r_sb[i_rd_a];
  assign o_hit_b = r_sb[i_rd_b];

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard/forwarding controller for the 5-stage core.
// Generates forwarding selects, load-use bubbles, branch flushes, the sticky
// halt latch, and tracks one multi-cycle mul/div op with a scoreboard.
//   clk, rst                 : clock, async active-high reset
//   i_id_req_a/b, i_id_use_a/b : ID source registers and whether they are read
//   i_stg_w_en/req_w/is_load : per forwarding stage (bit/slice k-1 = stage k)
//   i_md_start/is_div/req_w  : mul/div issue from ID
//   i_branch_taken, i_syscall_halt : EX-resolved control events
//   o_fwd_sel_a/b            : 0 = regfile, k = forward from stage k
//   o_stall_if/id, o_flush_id/ex : pipeline control
//   o_md_busy, o_md_done, o_md_wb_req : mul/div status and writeback register
//   o_halted                 : sticky halt
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int RA_W    = 5,
  localparam int SEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RA_W-1:0]         i_id_req_a,
  input  logic [RA_W-1:0]         i_id_req_b,
  input  logic                    i_id_use_a,
  input  logic                    i_id_use_b,
  input  logic [NUM_FWD-1:0]      i_stg_w_en,
  input  logic [NUM_FWD*RA_W-1:0] i_stg_req_w,
  input  logic [NUM_FWD-1:0]      i_stg_is_load,
  input  logic                    i_md_start,
  input  logic                    i_md_is_div,
  input  logic [RA_W-1:0]         i_md_req_w,
  input  logic                    i_branch_taken,
  input  logic                    i_syscall_halt,
  output logic [SEL_W-1:0]        o_fwd_sel_a,
  output logic [SEL_W-1:0]        o_fwd_sel_b,
  output logic                    o_stall_if,
  output logic                    o_stall_id,
  output logic                    o_flush_id,
  output logic                    o_flush_ex,
  output logic                    o_md_busy,
  output logic                    o_md_done,
  output logic [RA_W-1:0]         o_md_wb_req,
  output logic                    o_halted
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_busy, r_md_done, r_halted;
  logic [RA_W-1:0]  r_md_wb_req;

  logic [SEL_W-1:0] w_fwd_a, w_fwd_b;
  logic [RA_W-1:0]  w_ld_dst;
  logic             w_lu, w_raw, w_struct, w_hazard, w_stall, w_accept;
  logic             w_hit_a, w_hit_b;
  logic             w_unused;

  // Only the stage-1 load flag matters; older loads have their data.
  assign w_unused = ^i_stg_is_load;

  // Scan oldest to youngest so the youngest matching stage wins. A stage-1
  // load has no data yet, so it is skipped (load-use covers that case).
  always_comb begin
    w_fwd_a = SEL_W'(FWD_SEL_RF);
    w_fwd_b = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (i_stg_w_en[k-1] && !(k == 1 && i_stg_is_load[0])) begin
        if (i_id_use_a && i_id_req_a != '0 &&
            i_stg_req_w[(k-1)*RA_W +: RA_W] == i_id_req_a) w_fwd_a = SEL_W'(k);
        if (i_id_use_b && i_id_req_b != '0 &&
            i_stg_req_w[(k-1)*RA_W +: RA_W] == i_id_req_b) w_fwd_b = SEL_W'(k);
      end
    end
  end

  assign w_ld_dst = i_stg_req_w[RA_W-1:0];
  assign w_lu     = i_stg_w_en[0] && i_stg_is_load[0] && w_ld_dst != '0 &&
                    ((i_id_use_a && i_id_req_a == w_ld_dst) ||
                     (i_id_use_b && i_id_req_b == w_ld_dst));
  assign w_raw    = (i_id_use_a && i_id_req_a != '0 && w_hit_a) ||
                    (i_id_use_b && i_id_req_b != '0 && w_hit_b);
  assign w_struct = i_md_start && r_md_busy;
  assign w_hazard = w_lu || w_raw || w_struct;
  // A taken branch squashes the stalled instruction, so it lifts hazard stalls;
  // halt still freezes the front end.
  assign w_stall  = r_halted || (!i_branch_taken && w_hazard);
  assign w_accept = i_md_start && !w_stall && !i_branch_taken;

  assign o_fwd_sel_a = rst ? '0 : w_fwd_a;
  assign o_fwd_sel_b = rst ? '0 : w_fwd_b;
  assign o_stall_if  = rst || w_stall;
  assign o_stall_id  = rst || w_stall;
  assign o_flush_id  = !rst && i_branch_taken;
  assign o_flush_ex  = !rst && (i_branch_taken || w_hazard || r_halted);

  md_scoreboard #(.RA_W(RA_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_set     (w_accept),
    .i_set_req (i_md_req_w),
    .i_clr     (r_state == MD_ST_DONE),
    .i_clr_req (r_md_wb_req),
    .i_rd_a    (i_id_req_a),
    .i_rd_b    (i_id_req_b),
    .o_hit_a   (w_hit_a),
    .o_hit_b   (w_hit_b)
  );

  // Counter loads LAT-1 and DONE is entered as it reaches 0, giving an
  // issue-to-md_done spacing of exactly LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MD_ST_IDLE;
      r_cnt       <= '0;
      r_md_busy   <= 1'b0;
      r_md_done   <= 1'b0;
      r_md_wb_req <= '0;
    end else begin
      case (r_state)
        MD_ST_IDLE, MD_ST_DONE: begin
          r_md_done <= 1'b0;
          if (w_accept) begin
            r_state     <= MD_ST_BUSY;
            r_cnt       <= i_md_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            r_md_wb_req <= i_md_req_w;
            r_md_busy   <= 1'b1;
          end else begin
            r_state <= MD_ST_IDLE;
          end
        end
        MD_ST_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= MD_ST_DONE;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b1;
          end
        end
        default: r_state <= MD_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_halted <= 1'b0;
    else if (i_syscall_halt) r_halted <= 1'b1;
  end

  assign o_md_busy   = r_md_busy;
  assign o_md_done   = r_md_done;
  assign o_md_wb_req = r_md_wb_req;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;
  localparam int NF = 2, ML = 4, DL = 16, RW = 5, SW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic [RW-1:0] req_a, req_b, md_req_w;
  logic use_a, use_b, md_start, md_is_div, br, halt;
  logic [NF-1:0] w_en, is_load;
  logic [NF*RW-1:0] req_w;
  logic [SW-1:0] fwd_a, fwd_b;
  logic stall_if, stall_id, flush_id, flush_ex, md_busy, md_done, halted;
  logic [RW-1:0] wb_req;

  int total = 0, bad = 0;

  pipe_hazard_unit #(.NUM_FWD(NF), .MUL_LAT(ML), .DIV_LAT(DL), .RA_W(RW)) dut (
    .clk(clk), .rst(rst),
    .i_id_req_a(req_a), .i_id_req_b(req_b), .i_id_use_a(use_a), .i_id_use_b(use_b),
    .i_stg_w_en(w_en), .i_stg_req_w(req_w), .i_stg_is_load(is_load),
    .i_md_start(md_start), .i_md_is_div(md_is_div), .i_md_req_w(md_req_w),
    .i_branch_taken(br), .i_syscall_halt(halt),
    .o_fwd_sel_a(fwd_a), .o_fwd_sel_b(fwd_b), .o_stall_if(stall_if), .o_stall_id(stall_id),
    .o_flush_id(flush_id), .o_flush_ex(flush_ex), .o_md_busy(md_busy), .o_md_done(md_done),
    .o_md_wb_req(wb_req), .o_halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // The mul/div op is remembered by its issue cycle: busy strictly between
  // issue and issue+LAT, done at issue+LAT, destination pending for
  // cycles issue+1 .. issue+LAT.
  int cyc, md_iss, md_lat, md_dst;
  bit m_halted;
  bit e_busy, e_done, e_stall, e_fid, e_fex, e_acc, lu_a, lu_b;
  logic [SW-1:0] e_fa, e_fb;

  function automatic int youngest(logic [RW-1:0] r, logic u);
    if (!u || r == 0) return 0;
    for (int k = 1; k <= NF; k++) begin
      if (k == 1 && is_load[0]) continue;
      if (w_en[k-1] && req_w[(k-1)*RW +: RW] == r) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    cyc = 0; md_iss = -1000; md_lat = ML; md_dst = 0; m_halted = 0;
  endtask

  task automatic model_eval();
    bit pend, raw, haz;
    pend   = (cyc >= md_iss + 1) && (cyc <= md_iss + md_lat);
    e_busy = (cyc >= md_iss + 1) && (cyc <= md_iss + md_lat - 1);
    e_done = (cyc == md_iss + md_lat);
    lu_a = w_en[0] && is_load[0] && use_a && req_a != 0 && req_w[RW-1:0] == req_a;
    lu_b = w_en[0] && is_load[0] && use_b && req_b != 0 && req_w[RW-1:0] == req_b;
    e_fa = SW'(youngest(req_a, use_a));
    e_fb = SW'(youngest(req_b, use_b));
    raw = pend && md_dst != 0 && ((use_a && req_a == md_dst) || (use_b && req_b == md_dst));
    haz = lu_a || lu_b || raw || (md_start && e_busy);
    e_stall = m_halted || (!br && haz);
    e_fex = br || haz || m_halted;
    e_fid = br;
    e_acc = md_start && !e_stall && !br;
  endtask

  task automatic model_tick();
    if (e_acc) begin md_iss = cyc; md_lat = md_is_div ? DL : ML; md_dst = md_req_w; end
    if (halt) m_halted = 1;
    cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    req_a = '0; req_b = '0; use_a = 0; use_b = 0; w_en = '0; req_w = '0; is_load = '0;
    md_start = 0; md_is_div = 0; md_req_w = '0; br = 0; halt = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); nxt(); nxt(); rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst = 1; br = 1; w_en = 2'b01; is_load = 2'b01; req_w[RW-1:0] = 9;
    req_b = 9; use_b = 1; req_a = 4; use_a = 1; md_start = 1; md_req_w = 3;
    nxt(); #3;
    total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL reset_stall_if got=%0b exp=1", stall_if); end
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL reset_stall_id got=%0b exp=1", stall_id); end
    total++; if (flush_id !== 1'b0) begin bad++; $display("FAIL reset_flush_id got=%0b exp=0", flush_id); end
    total++; if (flush_ex !== 1'b0) begin bad++; $display("FAIL reset_flush_ex got=%0b exp=0", flush_ex); end
    total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL reset_fwd_b got=%0d exp=0", fwd_b); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%0b exp=0", md_busy); end
    total++; if (md_done !== 1'b0) begin bad++; $display("FAIL reset_md_done got=%0b exp=0", md_done); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    total++; if (wb_req !== '0) begin bad++; $display("FAIL reset_wb_req got=%0d exp=0", wb_req); end
    idle(); nxt(); rst = 0;
  endtask

  task automatic test_forwarding();
    nxt(); idle();
    w_en = 2'b01; req_w[RW-1:0] = 8; req_a = 8; use_a = 1; #3;
    total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL fwd_ex got=%0d exp=1", fwd_a); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL fwd_ex_stall got=%0b exp=0", stall_id); end
    w_en = 2'b11; req_w = {5'd8, 5'd8}; #1;
    total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL fwd_youngest got=%0d exp=1", fwd_a); end
    w_en = 2'b10; #1;
    total++; if (fwd_a !== 2'd2) begin bad++; $display("FAIL fwd_dm got=%0d exp=2", fwd_a); end
    req_b = 8; use_b = 1; use_a = 0; #1;
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL fwd_unused got=%0d exp=0", fwd_a); end
    total++; if (fwd_b !== 2'd2) begin bad++; $display("FAIL fwd_b_dm got=%0d exp=2", fwd_b); end
    idle(); w_en = 2'b10; req_w = '0; req_a = 0; use_a = 1; #1;
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL fwd_r0 got=%0d exp=0", fwd_a); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL fwd_r0_stall got=%0b exp=0", stall_id); end
  endtask

  task automatic test_load_use();
    nxt(); idle();
    w_en = 2'b01; is_load = 2'b01; req_w[RW-1:0] = 9; req_b = 9; use_b = 1; #3;
    total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL lu_stall_if got=%0b exp=1", stall_if); end
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_stall_id got=%0b exp=1", stall_id); end
    total++; if (flush_ex !== 1'b1) begin bad++; $display("FAIL lu_flush_ex got=%0b exp=1", flush_ex); end
    total++; if (flush_id !== 1'b0) begin bad++; $display("FAIL lu_flush_id got=%0b exp=0", flush_id); end
    nxt(); w_en = 2'b10; is_load = 2'b10; req_w = {5'd9, 5'd0}; #3;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_next_stall got=%0b exp=0", stall_id); end
    total++; if (fwd_b !== 2'd2) begin bad++; $display("FAIL lu_next_fwd_b got=%0d exp=2", fwd_b); end
  endtask

  task automatic test_div_raw();
    int n_stall, n_done;
    bit ok;
    n_stall = 0; n_done = 0; ok = 0;
    nxt(); idle(); md_start = 1; md_is_div = 1; md_req_w = 10; #3;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL div_issue_stall got=%0b exp=0", stall_id); end
    nxt(); idle(); req_a = 10; use_a = 1; #3;
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL div_busy got=%0b exp=1", md_busy); end
    for (int i = 0; i < 40; i++) begin
      if (md_done) begin
        n_done++;
        total++; if (wb_req !== 5'd10) begin bad++; $display("FAIL div_wb_req got=%0d exp=10", wb_req); end
      end
      if (!stall_id) begin ok = 1; break; end
      n_stall++;
      nxt(); #3;
    end
    total++; if (!ok) begin bad++; $display("FAIL div_timeout got=stalled exp=release"); end
    total++; if (n_stall != DL) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=%0d", n_stall, DL); end
    total++; if (n_done != 1) begin bad++; $display("FAIL div_done_pulses got=%0d exp=1", n_done); end
    total++; if (md_done !== 1'b0) begin bad++; $display("FAIL div_done_after got=%0b exp=0", md_done); end
  endtask

  task automatic test_struct_branch();
    nxt(); idle(); md_start = 1; md_req_w = 5; #3;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL mul_issue_stall got=%0b exp=0", stall_id); end
    for (int c = 1; c <= ML; c++) begin
      nxt(); md_req_w = 6; #3;
      total++; if (stall_id !== (c < ML)) begin bad++; $display("FAIL struct_stall_c%0d got=%0b exp=%0b", c, stall_id, c < ML); end
      if (c == ML) begin
        total++; if (md_done !== 1'b1) begin bad++; $display("FAIL struct_done got=%0b exp=1", md_done); end
        total++; if (wb_req !== 5'd5) begin bad++; $display("FAIL struct_wb_req got=%0d exp=5", wb_req); end
      end
    end
    nxt(); md_start = 0; req_a = 6; use_a = 1; #3;
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL second_busy got=%0b exp=1", md_busy); end
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL raw_stall got=%0b exp=1", stall_id); end
    nxt(); br = 1; #3;
    total++; if (flush_id !== 1'b1) begin bad++; $display("FAIL br_flush_id got=%0b exp=1", flush_id); end
    total++; if (flush_ex !== 1'b1) begin bad++; $display("FAIL br_flush_ex got=%0b exp=1", flush_ex); end
    total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL br_stall_if got=%0b exp=0", stall_if); end
    nxt(); idle(); nxt(); #3;
    total++; if (md_done !== 1'b1 || wb_req !== 5'd6) begin bad++; $display("FAIL second_done got=%0b/%0d exp=1/6", md_done, wb_req); end
  endtask

  task automatic test_halt_reset();
    int n_done;
    n_done = 0;
    nxt(); idle(); md_start = 1; md_is_div = 1; md_req_w = 11;
    nxt(); idle(); halt = 1; #3;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%0b exp=0", halted); end
    nxt(); halt = 0; #3;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%0b exp=1", halted); end
    total++; if (stall_if !== 1'b1 || flush_ex !== 1'b1) begin bad++; $display("FAIL halt_ctl got=%0b%0b exp=11", stall_if, flush_ex); end
    nxt(); #3;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%0b exp=1", halted); end
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL halt_md_busy got=%0b exp=1", md_busy); end
    rst = 1; #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=0", md_busy); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_mid_halted got=%0b exp=0", halted); end
    total++; if (stall_if !== 1'b1 || flush_ex !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl got=%0b%0b exp=10", stall_if, flush_ex); end
    nxt(); nxt(); rst = 0;
    for (int i = 0; i < 24; i++) begin nxt(); #3; if (md_done) n_done++; end
    total++; if (n_done != 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_random(input int cycles, input int halt_rate);
    do_reset(); model_reset();
    for (int i = 0; i < cycles; i++) begin
      nxt();
      req_a = RW'($urandom_range(0, 3)); req_b = RW'($urandom_range(0, 3));
      use_a = 1'($urandom); use_b = 1'($urandom);
      w_en = NF'($urandom); is_load = NF'($urandom);
      req_w = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
      md_start = ($urandom_range(0, 4) == 0); md_is_div = ($urandom_range(0, 3) == 0);
      md_req_w = RW'($urandom_range(0, 3));
      br = ($urandom_range(0, 7) == 0);
      halt = (halt_rate > 0) && ($urandom_range(0, halt_rate - 1) == 0);
      #3;
      model_eval();
      total++; if (stall_if !== e_stall) begin bad++; $display("FAIL rnd_stall_if c%0d got=%0b exp=%0b", cyc, stall_if, e_stall); end
      total++; if (stall_id !== e_stall) begin bad++; $display("FAIL rnd_stall_id c%0d got=%0b exp=%0b", cyc, stall_id, e_stall); end
      total++; if (flush_id !== e_fid) begin bad++; $display("FAIL rnd_flush_id c%0d got=%0b exp=%0b", cyc, flush_id, e_fid); end
      total++; if (flush_ex !== e_fex) begin bad++; $display("FAIL rnd_flush_ex c%0d got=%0b exp=%0b", cyc, flush_ex, e_fex); end
      total++; if (md_busy !== e_busy) begin bad++; $display("FAIL rnd_md_busy c%0d got=%0b exp=%0b", cyc, md_busy, e_busy); end
      total++; if (md_done !== e_done) begin bad++; $display("FAIL rnd_md_done c%0d got=%0b exp=%0b", cyc, md_done, e_done); end
      total++; if (halted !== m_halted) begin bad++; $display("FAIL rnd_halted c%0d got=%0b exp=%0b", cyc, halted, m_halted); end
      if (!lu_a) begin
        total++; if (fwd_a !== e_fa) begin bad++; $display("FAIL rnd_fwd_a c%0d got=%0d exp=%0d", cyc, fwd_a, e_fa); end
      end
      if (!lu_b) begin
        total++; if (fwd_b !== e_fb) begin bad++; $display("FAIL rnd_fwd_b c%0d got=%0d exp=%0d", cyc, fwd_b, e_fb); end
      end
      if (e_done) begin
        total++; if (wb_req !== RW'(md_dst)) begin bad++; $display("FAIL rnd_wb_req c%0d got=%0d exp=%0d", cyc, wb_req, md_dst); end
      end
      model_tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_div_raw();
    test_struct_branch();
    test_halt_reset();
    test_random(1500, 0);
    test_random(300, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
